// File: rtl/booth_r4_macc_seq.sv
// booth_r4_macc_seq: sequential radix-4 Booth multiply-accumulate controller.
//   Takes one signed 8x8 operand pair per transaction and retires one Booth
//   partial product per cycle through a single square-root carry-select adder
//   with binary-to-excess-1 converters. The product is then folded into a
//   running ACC_W-bit accumulator.
// Optional feature: define MACC_SAT_EN for a saturating accumulator and an
//   extra acc_sat output. Left undefined, the accumulator wraps and acc_sat
//   does not exist.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   a_in, b_in            signed multiplicand / multiplier
//   clear_acc             sampled with operands: restart accumulation at product
//   out_valid / out_ready result handshake
//   prod_out              signed 16-bit product of the completed transaction
//   acc_out               accumulator value after that transaction
//   acc_sat               (MACC_SAT_EN only) clamp fired on this transaction
//   busy                  high in any state other than IDLE
module booth_r4_macc_seq #(
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a_in,
  input  logic [7:0]       b_in,
  input  logic             clear_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      prod_out,
  output logic [ACC_W-1:0] acc_out,
`ifdef MACC_SAT_EN
  output logic             acc_sat,
`endif
  output logic             busy
);

  localparam int unsigned M_W = 10;
  localparam int unsigned P_W = 19;
  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [M_W-1:0]   m;
  logic [P_W-1:0]   p;
  logic             clr;
  logic [1:0]       cnt;
  logic [ACC_W-1:0] acc;

  logic [M_W-1:0]   pp_mag, pp_b;
  logic             pp_neg;
  logic [9:0]       csa_out;
  logic [M_W-1:0]   sum;
  logic [15:0]      prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_nxt;
  logic             sat_nxt;

  // 9-bit square-root carry-select adder; out[9] is the carry out of bit 8.
  // Upper groups precompute the carry-in=0 sum and derive the carry-in=1 sum
  // with a +1 (excess-1) converter, then select on the incoming group carry.
  function automatic logic [9:0] sqrt_csa_bec(input logic [8:0] a,
                                              input logic [8:0] b,
                                              input logic       cin);
    logic [2:0] g0, g1_r, g1_x, g1;
    logic [3:0] g2_r, g2_x, g2;
    logic [2:0] g3_r, g3_x, g3;
    g0   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    g1_r = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    g1_x = g1_r + 3'd1;
    g1   = g0[2] ? g1_x : g1_r;
    g2_r = {1'b0, a[6:4]} + {1'b0, b[6:4]};
    g2_x = g2_r + 4'd1;
    g2   = g1[2] ? g2_x : g2_r;
    g3_r = {1'b0, a[8:7]} + {1'b0, b[8:7]};
    g3_x = g3_r + 3'd1;
    g3   = g2[3] ? g3_x : g3_r;
    return {g3, g2[2:0], g1[1:0], g0[1:0]};
  endfunction

  // Booth digit decode from the low three bits of the shifting product register
  always_comb begin
    pp_mag = '0;
    pp_neg = 1'b0;
    case (p[2:0])
      3'b001, 3'b010: pp_mag = m;
      3'b011:         pp_mag = {m[8:0], 1'b0};
      3'b100: begin
        pp_mag = {m[8:0], 1'b0};
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = m;
        pp_neg = 1'b1;
      end
      default: ;
    endcase
  end

  // Subtraction as invert-plus-carry-in; bit 9 completed outside the 9-bit adder
  assign pp_b    = pp_neg ? ~pp_mag : pp_mag;
  assign csa_out = sqrt_csa_bec(p[17:9], pp_b[8:0], pp_neg);
  assign sum     = {p[18] ^ pp_b[9] ^ csa_out[9], csa_out[8:0]};

  assign prod     = p[16:1];
  assign prod_ext = ACC_W'($signed(prod));

`ifdef MACC_SAT_EN
  logic [SUM_W-1:0] sum_wide;

  // One guard bit detects signed overflow; clamp toward the overflow direction
  always_comb begin
    sum_wide = SUM_W'($signed(acc)) + SUM_W'($signed(prod_ext));
    acc_nxt  = sum_wide[ACC_W-1:0];
    sat_nxt  = 1'b0;
    if (clr) begin
      acc_nxt = prod_ext;
    end else if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sat_nxt = 1'b1;
      acc_nxt = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    sat_nxt = 1'b0;
    acc_nxt = clr ? prod_ext : acc + prod_ext;
  end
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ITER;
      ITER:    if (cnt == 2'd3) state_nxt = ACC;
      ACC:     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Datapath: operand capture, Booth iterations, accumulate
  always_ff @(posedge clk) begin
    if (rst) begin
      m        <= '0;
      p        <= '0;
      clr      <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      prod_out <= '0;
      acc_out  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          m   <= M_W'($signed(a_in));
          p   <= {10'b0, b_in, 1'b0};
          clr <= clear_acc;
          cnt <= '0;
        end
        ITER: begin
          p   <= {{2{sum[9]}}, sum, p[8:2]};
          cnt <= cnt + 2'd1;
        end
        ACC: begin
          acc      <= acc_nxt;
          prod_out <= prod;
          acc_out  <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

`ifdef MACC_SAT_EN
  // Clamp flag follows the result it describes
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_sat <= 1'b0;
    end else if (state == ACC) begin
      acc_sat <= sat_nxt;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_nxt;
`endif

endmodule
